// File: rtl/reg_wr_arbiter.sv
// Arbitrates the register-file write port between core writeback and a burst register loader.
// Latency: one cycle from grant to rf_*; loader bursts yield to core until the starvation cap is reached.
module reg_wr_arbiter #(
    parameter int PW         = 4,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic [PW-1:0] core_addr,
    input  logic [DW-1:0] core_data,
    output logic          core_gnt,
    input  logic          ld_req,
    input  logic [PW-1:0] ld_addr,
    input  logic [PW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          rf_wr_en,
    output logic [PW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    output logic          rf_src
);

    localparam int SW = 3;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic [PW-1:0] beat_q;
    logic [PW-1:0] base_q;
    logic [PW-1:0] len_q;
    logic          ld_busy_q;
    logic          ld_done_q;
    logic          rf_wr_en_q;
    logic [PW-1:0] rf_addr_q;
    logic [DW-1:0] rf_data_q;
    logic          rf_src_q;

    logic          in_burst;
    logic          loader_wins;
    logic          beat_xfer;
    logic          last_beat;
    logic [PW-1:0] beat_addr;

    assign in_burst    = (state_q == BURST);
    assign loader_wins = (starve_q == STARVE_LIM) || !core_req;
    assign last_beat   = (beat_q == len_q);
    // Natural PW-bit truncation gives the wrap from the top register back to 0.
    assign beat_addr   = base_q + beat_q;

    // Grants are gated by reset_n so nothing is offered while reset is held.
    assign ld_ready  = reset_n && in_burst && loader_wins;
    assign beat_xfer = ld_valid && ld_ready;
    assign core_gnt  = reset_n && core_req && !(in_burst && ld_valid && loader_wins);

    assign ld_busy  = ld_busy_q;
    assign ld_done  = ld_done_q;
    assign rf_wr_en = rf_wr_en_q;
    assign rf_addr  = rf_addr_q;
    assign rf_data  = rf_data_q;
    assign rf_src   = rf_src_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            ld_busy_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            rf_wr_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            rf_src_q   <= 1'b0;
        end else begin
            ld_done_q  <= 1'b0;
            rf_wr_en_q <= 1'b0;

            if (core_gnt) begin
                rf_wr_en_q <= 1'b1;
                rf_addr_q  <= core_addr;
                rf_data_q  <= core_data;
                rf_src_q   <= 1'b0;
            end else if (beat_xfer) begin
                rf_wr_en_q <= 1'b1;
                rf_addr_q  <= beat_addr;
                rf_data_q  <= ld_data;
                rf_src_q   <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ld_req) begin
                        state_q   <= BURST;
                        base_q    <= ld_addr;
                        len_q     <= ld_len;
                        beat_q    <= '0;
                        starve_q  <= '0;
                        ld_busy_q <= 1'b1;
                    end
                end
                BURST: begin
                    if (beat_xfer) begin
                        starve_q <= '0;
                        if (last_beat) begin
                            state_q   <= IDLE;
                            ld_busy_q <= 1'b0;
                            ld_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end else if (ld_valid && core_req && !loader_wins) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ld_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reference control model plus a write scoreboard.
module tb_reg_wr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       core_req;
    logic [3:0] core_addr;
    logic [7:0] core_data;
    logic       core_gnt;
    logic       ld_req;
    logic [3:0] ld_addr;
    logic [3:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_busy;
    logic       ld_done;
    logic       rf_wr_en;
    logic [3:0] rf_addr;
    logic [7:0] rf_data;
    logic       rf_src;

    reg_wr_arbiter #(.PW(4), .DW(8), .STARVE_MAX(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_gnt(core_gnt),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
        .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_data(rf_data), .rf_src(rf_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       s;
    } wr_t;

    wr_t        sb[$];
    logic [3:0] log_addr[$];
    logic       log_src[$];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;

    logic       m_burst, m_done;
    logic [2:0] m_starve;
    logic [3:0] m_beat, m_base, m_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_burst = 0; m_done = 0; m_starve = 0; m_beat = 0; m_base = 0; m_len = 0;
        sb.delete();
    endtask

    task automatic idle_inputs();
        core_req = 0; core_addr = 0; core_data = 0;
        ld_req = 0; ld_addr = 0; ld_len = 0; ld_valid = 0; ld_data = 0;
    endtask

    // One clock: check combinational grants before the edge, registered outputs after it.
    task automatic cycle(input string tag);
        logic lw, xfer, e_gnt, e_rdy, e_we;
        wr_t  w;
        @(negedge clk);
        lw    = (m_starve == 3'd3) || !core_req;
        e_rdy = m_burst && lw;
        xfer  = e_rdy && ld_valid;
        e_gnt = core_req && !xfer;
        e_we  = e_gnt || xfer;
        chk({tag, ".core_gnt"}, core_gnt, e_gnt);
        chk({tag, ".ld_ready"}, ld_ready, e_rdy);
        if (e_gnt) begin
            w.a = core_addr; w.d = core_data; w.s = 1'b0; sb.push_back(w);
        end else if (xfer) begin
            w.a = m_base + m_beat; w.d = ld_data; w.s = 1'b1; sb.push_back(w);
        end
        m_done = 0;
        if (!m_burst) begin
            if (ld_req) begin
                m_burst = 1; m_base = ld_addr; m_len = ld_len; m_beat = 0; m_starve = 0;
            end
        end else if (xfer) begin
            m_starve = 0;
            if (m_beat == m_len) begin
                m_burst = 0; m_done = 1;
            end else begin
                m_beat = m_beat + 4'd1;
            end
        end else if (ld_valid && core_req) begin
            m_starve = m_starve + 3'd1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rf_wr_en"}, rf_wr_en, e_we);
        if (e_we && sb.size() > 0) begin
            w = sb.pop_front();
            chk({tag, ".rf_addr"}, rf_addr, w.a);
            chk({tag, ".rf_data"}, rf_data, w.d);
            chk({tag, ".rf_src"}, rf_src, w.s);
            log_addr.push_back(rf_addr);
            log_src.push_back(rf_src);
        end
        chk({tag, ".ld_busy"}, ld_busy, m_burst);
        chk({tag, ".ld_done"}, ld_done, m_done);
        if (ld_done) done_cnt++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".core_gnt"}, core_gnt, 0);
        chk({tag, ".ld_ready"}, ld_ready, 0);
        chk({tag, ".ld_busy"}, ld_busy, 0);
        chk({tag, ".ld_done"}, ld_done, 0);
        chk({tag, ".rf_wr_en"}, rf_wr_en, 0);
        chk({tag, ".rf_addr"}, rf_addr, 0);
        chk({tag, ".rf_data"}, rf_data, 0);
        chk({tag, ".rf_src"}, rf_src, 0);
    endtask

    initial begin
        logic [3:0] exp_addr[4];
        logic       exp_src[8];
        int         n;
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        exp_src  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state, with requests active to prove the grants are gated
        idle_inputs();
        core_req = 1;
        reset_n  = 0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        idle_inputs();

        // Core-only single write
        core_req = 1; core_addr = 4'd3; core_data = 8'hA5;
        cycle("core");
        idle_inputs();
        chk("core.write_count", log_addr.size(), 1);
        cycle("core_idle");

        // Burst wrapping past the top register
        log_addr.delete(); log_src.delete(); done_cnt = 0;
        ld_req = 1; ld_addr = 4'd14; ld_len = 4'd3; ld_valid = 1; ld_data = 8'h10;
        cycle("wrap_start");
        ld_req = 0;
        for (int i = 0; i < 5; i++) begin
            ld_data = 8'h20 + 8'(i);
            cycle("wrap");
        end
        ld_valid = 0;
        chk("wrap.beats", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("wrap.addr_seq", log_addr[i], exp_addr[i]);
            chk("wrap.src_seq", log_src[i], 1);
        end
        chk("wrap.done_pulses", done_cnt, 1);

        // Starvation cap with both requesters saturated
        log_addr.delete(); log_src.delete(); done_cnt = 0;
        ld_req = 1; ld_addr = 4'd2; ld_len = 4'd7;
        cycle("starve_start");
        ld_req = 0; ld_valid = 1; core_req = 1;
        for (int i = 0; i < 8; i++) begin
            core_addr = 4'(i); core_data = 8'hC0 + 8'(i); ld_data = 8'h50 + 8'(i);
            cycle("starve");
        end
        chk("starve.writes", log_src.size(), 8);
        for (int i = 0; i < 8 && i < log_src.size(); i++)
            chk("starve.src_seq", log_src[i], exp_src[i]);
        core_req = 0;
        n = 0;
        while (m_burst && n < 20) begin
            ld_data = 8'h60 + 8'(n);
            cycle("starve_drain");
            n++;
        end
        chk("starve.drain_bound", m_burst, 0);
        chk("starve.done_pulses", done_cnt, 1);
        idle_inputs();

        // Loader start and core write in the same IDLE cycle
        log_addr.delete(); log_src.delete(); done_cnt = 0;
        ld_req = 1; ld_addr = 4'd9; ld_len = 4'd0; core_req = 1; core_addr = 4'd7; core_data = 8'h3C;
        cycle("overlap_start");
        idle_inputs();
        chk("overlap.core_written", log_addr.size(), 1);
        ld_valid = 1; ld_data = 8'h77;
        cycle("overlap_beat");
        ld_valid = 0;
        cycle("overlap_end");
        chk("overlap.done_pulses", done_cnt, 1);

        // Reset abandons a burst after two of five beats
        log_addr.delete(); log_src.delete(); done_cnt = 0;
        ld_req = 1; ld_addr = 4'd5; ld_len = 4'd4;
        cycle("rst_start");
        ld_req = 0; ld_valid = 1;
        for (int i = 0; i < 2; i++) begin
            ld_data = 8'h90 + 8'(i);
            cycle("rst_beat");
        end
        core_req = 1;
        #2;
        reset_n = 0;
        #1;
        chk_all_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        reset_n = 1;
        idle_inputs();
        chk("rst.no_done", done_cnt, 0);
        cycle("rst_idle");

        log_addr.delete(); log_src.delete(); done_cnt = 0;
        ld_req = 1; ld_addr = 4'd0; ld_len = 4'd2;
        cycle("fresh_start");
        ld_req = 0; ld_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 8'hE0 + 8'(i);
            cycle("fresh");
        end
        idle_inputs();
        chk("fresh.beats", log_addr.size(), 3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++)
            chk("fresh.addr_seq", log_addr[i], 4'(i));
        chk("fresh.done_pulses", done_cnt, 1);
        chk("final.sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the core writeback stage (single writes);
  - a register loader (multi-beat bursts to consecutive registers; used for init and context restore).
- Sits directly in front of the register file's write inputs.
- Arbitrates per cycle and registers the winning write.
- A starvation cap keeps the core from locking out a loader burst indefinitely.

Parameters:
- PW, 4, register address width; register count = 2**PW.
- DW, 8, data width.
- STARVE_MAX, 3, consecutive loader losses after which the loader wins one cycle (1..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- core_req  in  1  core requests a write this cycle.
- core_addr  in  PW  core write address.
- core_data  in  DW  core write data.
- core_gnt  out  1  combinational; core write accepted this cycle.
- ld_req  in  1  loader requests burst start; sampled only in IDLE.
- ld_addr  in  PW  burst start address, latched at start.
- ld_len  in  PW  burst beats minus 1, latched at start (beats = ld_len+1).
- ld_valid  in  1  loader beat data valid.
- ld_data  in  DW  loader beat data.
- ld_ready  out  1  combinational; loader beat may be accepted this cycle.
- ld_busy  out  1  registered; high while in BURST.
- ld_done  out  1  registered; one-cycle pulse after the last beat is accepted.
- rf_wr_en  out  1  registered write enable to the register file.
- rf_addr  out  PW  registered write address.
- rf_data  out  DW  registered write data.
- rf_src  out  1  registered; 0 = core, 1 = loader.

Behaviour:
- **Reset:** reset_n low asynchronously forces:
  - state = IDLE; starve_cnt = 0; beat index = 0; latched addr/len = 0;
  - rf_wr_en = 0, rf_addr = 0, rf_data = 0, rf_src = 0, ld_busy = 0, ld_done = 0;
  - core_gnt = 0 and ld_ready = 0 while reset_n is low.
- **Reset mid-burst:** burst is abandoned; no ld_done pulse; any write not yet presented is lost.
- **State IDLE:**
  - core_gnt = core_req.
  - ld_ready = 0.
  - If ld_req: latch ld_addr/ld_len, beat index = 0, go to BURST next cycle, ld_busy = 1 next cycle.
  - The start cycle never uses the write port, so a core write in the same cycle is still granted.
- **State BURST (ld_req ignored):**
  - loader_wins = (starve_cnt == STARVE_MAX) || !core_req.
  - ld_ready = loader_wins.
  - core_gnt = core_req && !(ld_valid && loader_wins).
  - A beat transfers when ld_valid && ld_ready.
  - Beat address = (start + beat index) mod 2**PW; wraps from 2**PW-1 to 0.
- **starve_cnt (BURST only):**
  - Increments when ld_valid && core_req && !loader_wins.
  - Clears when a beat transfers.
  - Holds otherwise.
  - Never exceeds STARVE_MAX.
- **Write path (1-cycle latency):** the granted write of cycle N appears on rf_* in cycle N+1.
  - rf_wr_en = 1 for exactly one cycle per granted write.
  - rf_addr/rf_data/rf_src hold their last values when rf_wr_en = 0.
  - At most one write per cycle; back-to-back grants give back-to-back rf_wr_en.
- **Last beat** (beat index == latched len, accepted in cycle N):
  - state = IDLE, ld_busy = 0, ld_done = 1, all in cycle N+1.
  - ld_done is high for one cycle; starve_cnt clears.
  - A new ld_req is honoured from cycle N+1.
- **Loader idle in BURST:** ld_valid low in BURST means the core is always granted and the burst stays open indefinitely; no timeout.

Test Plan:
1. **Core only:** core_req with addr 3, data 8'hA5 for 1 cycle -> core_gnt = 1 same cycle; next cycle rf_wr_en = 1, rf_addr = 3, rf_data = A5, rf_src = 0.
2. **Burst wrap:** ld_req with ld_addr = 14, ld_len = 3, ld_valid held high, no core traffic.
   - ld_busy rises 1 cycle after ld_req.
   - rf_addr sequence is 14, 15, 0, 1 with rf_src = 1.
   - ld_done pulses once, the cycle after the 4th beat is accepted.
3. **Starvation cap:** core_req and ld_valid held high during a burst (STARVE_MAX = 3).
   - Grant pattern is core, core, core, loader, repeating.
   - rf_src sequence is 0,0,0,1,0,0,0,1.
4. **Start overlap:** in IDLE, ld_req and core_req in the same cycle -> core granted that cycle; ld_busy = 1 next cycle; no write dropped.
5. **Reset mid-burst:** drop reset_n after 2 of 5 beats.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - No ld_done pulse.
   - After release, state is IDLE and a fresh burst from addr 0 completes normally.
